// File: rtl/gip_sram_dp_arbiter_pkg.sv
// Shared types and constants for the GIP dual-port SRAM arbiter.
package gip_sram_arb_pkg;

  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DATA_W = 32;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  // Read-side FSM: single-cycle grant in IDLE, extra beats in BURST
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  // Client identity, also the bit position of that client in req/grant vectors
  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_t;

endpackage

// File: rtl/gip_sram_dp_arbiter_if.sv
// Client and SRAM-macro side signals of the dual-port SRAM arbiter.
// master = clients plus the SRAM macro, slave = the arbiter itself.
interface gip_sram_dp_arbiter_if
  import gip_sram_arb_pkg::*;
#(
  parameter int BURST_BITS = 3
) ();

  // Read clients
  logic                  rd_req_a;
  logic                  rd_req_b;
  sram_addr_t            rd_addr_a;
  sram_addr_t            rd_addr_b;
  logic [BURST_BITS-1:0] rd_len_a;
  logic [BURST_BITS-1:0] rd_len_b;
  logic                  rd_ack_a;
  logic                  rd_ack_b;
  logic                  rd_valid_a;
  logic                  rd_valid_b;
  logic                  rd_last_a;
  logic                  rd_last_b;
  sram_data_t            rd_data;

  // Write clients
  logic                  wr_req_a;
  logic                  wr_req_b;
  sram_addr_t            wr_addr_a;
  sram_addr_t            wr_addr_b;
  sram_data_t            wr_data_a;
  sram_data_t            wr_data_b;
  logic                  wr_ack_a;
  logic                  wr_ack_b;

  // SRAM macro ports
  logic                  sram_read;
  sram_addr_t            sram_read_address;
  sram_data_t            sram_read_data;
  logic                  sram_write;
  sram_addr_t            sram_write_address;
  sram_data_t            sram_write_data;

  modport slave (
    input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, rd_len_a, rd_len_b,
    output rd_ack_a, rd_ack_b, rd_valid_a, rd_valid_b, rd_last_a, rd_last_b, rd_data,
    input  wr_req_a, wr_req_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    output wr_ack_a, wr_ack_b,
    output sram_read, sram_read_address, sram_write, sram_write_address, sram_write_data,
    input  sram_read_data
  );

  modport master (
    output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, rd_len_a, rd_len_b,
    input  rd_ack_a, rd_ack_b, rd_valid_a, rd_valid_b, rd_last_a, rd_last_b, rd_data,
    output wr_req_a, wr_req_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    input  wr_ack_a, wr_ack_b,
    input  sram_read, sram_read_address, sram_write, sram_write_address, sram_write_data,
    output sram_read_data
  );

endinterface

// File: rtl/gip_sram_dp_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from req; the
// priority pointer only moves when the caller says the grant was used.
module gip_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic favour_b;

  // Lone requester always wins; on contention the pointer decides
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = favour_b ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After a used grant, hand priority to the client that did not win
  always_ff @(posedge clock) begin
    if (reset) begin
      favour_b <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      favour_b <= grant[0];
    end
  end

endmodule

// File: rtl/gip_sram_dp_arbiter.sv
// Shares one simple dual-port 2048x32 SRAM between two read clients
// (round-robin, 1..2^BURST_BITS word bursts) and two write clients
// (independent single-beat round-robin).
module gip_sram_dp_arbiter
  import gip_sram_arb_pkg::*;
#(
  parameter int BURST_BITS = 3
) (
  input  logic                   sram_clock,
  input  logic                   sram_reset,
  gip_sram_dp_arbiter_if.slave   bus
);

  rd_state_t             state;
  client_t               owner;
  sram_addr_t            burst_addr;
  logic [BURST_BITS-1:0] remaining;
  logic                  valid_a;
  logic                  valid_b;
  logic                  last_a;
  logic                  last_b;

  logic [1:0]            rd_req_vec;
  logic [1:0]            rd_grant;
  logic                  rd_advance;
  logic                  rd_start;
  logic                  rd_win_b;
  sram_addr_t            rd_sel_addr;
  logic [BURST_BITS-1:0] rd_sel_len;

  logic [1:0]            wr_req_vec;
  logic [1:0]            wr_grant;
  logic                  wr_advance;

  assign rd_req_vec = {bus.rd_req_b, bus.rd_req_a};
  assign wr_req_vec = {bus.wr_req_b, bus.wr_req_a};

  // Read arbitration only counts while IDLE; bursts freeze the pointer
  assign rd_advance = (state == IDLE) && !sram_reset;
  assign wr_advance = !sram_reset;

  gip_rr_arb2 u_rd_arb (
    .clock   (sram_clock),
    .reset   (sram_reset),
    .req     (rd_req_vec),
    .advance (rd_advance),
    .grant   (rd_grant)
  );

  gip_rr_arb2 u_wr_arb (
    .clock   (sram_clock),
    .reset   (sram_reset),
    .req     (wr_req_vec),
    .advance (wr_advance),
    .grant   (wr_grant)
  );

  assign rd_start    = rd_advance && (rd_grant != 2'b00);
  assign rd_win_b    = rd_grant[1];
  assign rd_sel_addr = rd_win_b ? bus.rd_addr_b : bus.rd_addr_a;
  assign rd_sel_len  = rd_win_b ? bus.rd_len_b  : bus.rd_len_a;

  assign bus.rd_ack_a          = rd_start && rd_grant[0];
  assign bus.rd_ack_b          = rd_start && rd_grant[1];
  assign bus.sram_read         = !sram_reset && ((state == BURST) || (rd_req_vec != 2'b00));
  assign bus.sram_read_address = (state == BURST) ? burst_addr : rd_sel_addr;
  assign bus.rd_data           = bus.sram_read_data;
  assign bus.rd_valid_a        = valid_a;
  assign bus.rd_valid_b        = valid_b;
  assign bus.rd_last_a         = last_a;
  assign bus.rd_last_b         = last_b;

  assign bus.wr_ack_a           = !sram_reset && wr_grant[0];
  assign bus.wr_ack_b           = !sram_reset && wr_grant[1];
  assign bus.sram_write         = !sram_reset && (wr_req_vec != 2'b00);
  assign bus.sram_write_address = wr_grant[1] ? bus.wr_addr_b : bus.wr_addr_a;
  assign bus.sram_write_data    = wr_grant[1] ? bus.wr_data_b : bus.wr_data_a;

  // Read FSM: issue beats, track burst owner/address/count, flag valid/last one cycle later
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state      <= IDLE;
      owner      <= CLIENT_A;
      burst_addr <= '0;
      remaining  <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      last_a     <= 1'b0;
      last_b     <= 1'b0;
    end else begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      last_a  <= 1'b0;
      last_b  <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            owner      <= rd_win_b ? CLIENT_B : CLIENT_A;
            burst_addr <= rd_sel_addr + 1'b1;
            remaining  <= rd_sel_len;
            valid_a    <= !rd_win_b;
            valid_b    <= rd_win_b;
            last_a     <= !rd_win_b && (rd_sel_len == '0);
            last_b     <= rd_win_b && (rd_sel_len == '0);
            if (rd_sel_len != '0) begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          burst_addr <= burst_addr + 1'b1;
          remaining  <= remaining - 1'b1;
          valid_a    <= (owner == CLIENT_A);
          valid_b    <= (owner == CLIENT_B);
          last_a     <= (owner == CLIENT_A) && (remaining == BURST_BITS'(1));
          last_b     <= (owner == CLIENT_B) && (remaining == BURST_BITS'(1));
          if (remaining == BURST_BITS'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gip_sram_dp_arbiter.sv
// Directed, table-driven bench for gip_sram_dp_arbiter with a write-first
// SRAM macro model.
module tb_gip_sram_dp_arbiter;
  import gip_sram_arb_pkg::*;

  typedef struct {
    logic        rst;
    logic [1:0]  rd_req;
    logic [10:0] rd_addr_a;
    logic [10:0] rd_addr_b;
    logic [2:0]  rd_len_a;
    logic [2:0]  rd_len_b;
    logic [1:0]  wr_req;
    logic [10:0] wr_addr_a;
    logic [10:0] wr_addr_b;
    logic [31:0] wr_data_a;
    logic [31:0] wr_data_b;
    logic [1:0]  exp_rd_ack;
    logic        exp_sread;
    logic [10:0] exp_sraddr;
    logic [1:0]  exp_wr_ack;
    logic        exp_swrite;
    logic [10:0] exp_swaddr;
    logic [1:0]  exp_valid;
    logic [1:0]  exp_last;
    logic        exp_dchk;
    logic [31:0] exp_data;
  } vec_t;

  logic sram_clock = 1'b0;
  logic sram_reset;
  logic [31:0] mem [0:2047];
  vec_t tbl [27];
  int checks = 0;
  int errors = 0;

  gip_sram_dp_arbiter_if #(.BURST_BITS(3)) bus ();

  gip_sram_dp_arbiter #(.BURST_BITS(3)) dut (
    .sram_clock (sram_clock),
    .sram_reset (sram_reset),
    .bus        (bus)
  );

  always #5 sram_clock = ~sram_clock;

  // SRAM macro model: registered read address, write-first on same-address collision
  always @(posedge sram_clock) begin
    if (bus.sram_write) mem[bus.sram_write_address] <= bus.sram_write_data;
    if (bus.sram_read) begin
      if (bus.sram_write && (bus.sram_write_address == bus.sram_read_address))
        bus.sram_read_data <= bus.sram_write_data;
      else
        bus.sram_read_data <= mem[bus.sram_read_address];
    end
  end

  // Safety net in case the run never reaches its summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sram_reset    = v.rst;
    bus.rd_req_a  = v.rd_req[0];
    bus.rd_req_b  = v.rd_req[1];
    bus.rd_addr_a = v.rd_addr_a;
    bus.rd_addr_b = v.rd_addr_b;
    bus.rd_len_a  = v.rd_len_a;
    bus.rd_len_b  = v.rd_len_b;
    bus.wr_req_a  = v.wr_req[0];
    bus.wr_req_b  = v.wr_req[1];
    bus.wr_addr_a = v.wr_addr_a;
    bus.wr_addr_b = v.wr_addr_b;
    bus.wr_data_a = v.wr_data_a;
    bus.wr_data_b = v.wr_data_b;
  endtask

  task automatic checkOutput(input vec_t v, input int idx, input bit post_edge);
    logic [31:0] exp_wdata;
    if (!post_edge) begin
      check($sformatf("v%0d rd_ack", idx), 32'({bus.rd_ack_b, bus.rd_ack_a}), 32'(v.exp_rd_ack));
      check($sformatf("v%0d sram_read", idx), 32'(bus.sram_read), 32'(v.exp_sread));
      if (v.exp_sread)
        check($sformatf("v%0d sram_read_address", idx), 32'(bus.sram_read_address), 32'(v.exp_sraddr));
      check($sformatf("v%0d wr_ack", idx), 32'({bus.wr_ack_b, bus.wr_ack_a}), 32'(v.exp_wr_ack));
      check($sformatf("v%0d sram_write", idx), 32'(bus.sram_write), 32'(v.exp_swrite));
      if (v.exp_swrite) begin
        exp_wdata = v.exp_wr_ack[1] ? v.wr_data_b : v.wr_data_a;
        check($sformatf("v%0d sram_write_address", idx), 32'(bus.sram_write_address), 32'(v.exp_swaddr));
        check($sformatf("v%0d sram_write_data", idx), bus.sram_write_data, exp_wdata);
      end
    end else begin
      check($sformatf("v%0d rd_valid", idx), 32'({bus.rd_valid_b, bus.rd_valid_a}), 32'(v.exp_valid));
      check($sformatf("v%0d rd_last", idx), 32'({bus.rd_last_b, bus.rd_last_a}), 32'(v.exp_last));
      if (v.exp_dchk)
        check($sformatf("v%0d rd_data", idx), bus.rd_data, v.exp_data);
    end
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge sram_clock);
      applyStimulus(tbl[i]);
      #1;
      checkOutput(tbl[i], i, 1'b0);
      @(posedge sram_clock);
      #1;
      checkOutput(tbl[i], i, 1'b1);
    end
  endtask

  initial begin
    int ack_b_cycle;
    int va_count;
    int last_a_cycle;
    int vb_count;

    // Reset held with every request raised: no acks or strobes may escape
    tbl[0]  = '{1'b1, 2'b11, 11'h005, 11'h100, 3'd0, 3'd0, 2'b11, 11'h005, 11'h100, 32'h1, 32'h2, 2'b00, 1'b0, 11'h0, 2'b00, 1'b0, 11'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[1]  = tbl[0];
    // Preload through the write port, exercising write round-robin
    tbl[2]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b11, 11'h005, 11'h100, 32'h11111111, 32'h0BADF00D, 2'b00, 1'b0, 11'h0, 2'b01, 1'b1, 11'h005, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b11, 11'h7FE, 11'h100, 32'hA0A0A0A0, 32'h0BADF00D, 2'b00, 1'b0, 11'h0, 2'b10, 1'b1, 11'h100, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b01, 11'h7FE, 11'h0, 32'hA0A0A0A0, 32'h0, 2'b00, 1'b0, 11'h0, 2'b01, 1'b1, 11'h7FE, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b10, 11'h0, 11'h7FF, 32'h0, 32'hB1B1B1B1, 2'b00, 1'b0, 11'h0, 2'b10, 1'b1, 11'h7FF, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b11, 11'h000, 11'h001, 32'hC0C0C0C0, 32'hD1D1D1D1, 2'b00, 1'b0, 11'h0, 2'b01, 1'b1, 11'h000, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b10, 11'h0, 11'h001, 32'h0, 32'hD1D1D1D1, 2'b00, 1'b0, 11'h0, 2'b10, 1'b1, 11'h001, 2'b00, 2'b00, 1'b0, 32'h0};
    // Single read of A
    tbl[8]  = '{1'b0, 2'b01, 11'h005, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b01, 1'b1, 11'h005, 2'b00, 1'b0, 11'h0, 2'b01, 2'b01, 1'b1, 32'h11111111};
    // Burst of 4 from B wrapping 0x7FE..0x001; A's request waits until the burst ends
    tbl[9]  = '{1'b0, 2'b10, 11'h0, 11'h7FE, 3'd0, 3'd3, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b10, 1'b1, 11'h7FE, 2'b00, 1'b0, 11'h0, 2'b10, 2'b00, 1'b1, 32'hA0A0A0A0};
    tbl[10] = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b00, 1'b1, 11'h7FF, 2'b00, 1'b0, 11'h0, 2'b10, 2'b00, 1'b1, 32'hB1B1B1B1};
    tbl[11] = '{1'b0, 2'b01, 11'h005, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b00, 1'b1, 11'h000, 2'b00, 1'b0, 11'h0, 2'b10, 2'b00, 1'b1, 32'hC0C0C0C0};
    tbl[12] = '{1'b0, 2'b01, 11'h005, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b00, 1'b1, 11'h001, 2'b00, 1'b0, 11'h0, 2'b10, 2'b10, 1'b1, 32'hD1D1D1D1};
    tbl[13] = '{1'b0, 2'b01, 11'h005, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b01, 1'b1, 11'h005, 2'b00, 1'b0, 11'h0, 2'b01, 2'b01, 1'b1, 32'h11111111};
    // Fairness: both sides held, reads start at B (A won last), writes at A
    tbl[14] = '{1'b0, 2'b11, 11'h005, 11'h100, 3'd0, 3'd0, 2'b11, 11'h200, 11'h201, 32'h22222222, 32'h33333333, 2'b10, 1'b1, 11'h100, 2'b01, 1'b1, 11'h200, 2'b10, 2'b10, 1'b1, 32'h0BADF00D};
    tbl[15] = '{1'b0, 2'b11, 11'h005, 11'h100, 3'd0, 3'd0, 2'b11, 11'h200, 11'h201, 32'h22222222, 32'h33333333, 2'b01, 1'b1, 11'h005, 2'b10, 1'b1, 11'h201, 2'b01, 2'b01, 1'b1, 32'h11111111};
    tbl[16] = tbl[14];
    tbl[17] = tbl[15];
    // Same-address read/write collision returns the new data
    tbl[18] = '{1'b0, 2'b01, 11'h100, 11'h0, 3'd0, 3'd0, 2'b01, 11'h100, 11'h0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 11'h100, 2'b01, 1'b1, 11'h100, 2'b01, 2'b01, 1'b1, 32'hDEADBEEF};
    tbl[19] = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b00, 1'b0, 11'h0, 2'b00, 1'b0, 11'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    // Reset during the 3rd beat of a len-7 burst from A
    tbl[20] = '{1'b0, 2'b01, 11'h005, 11'h0, 3'd7, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b01, 1'b1, 11'h005, 2'b00, 1'b0, 11'h0, 2'b01, 2'b00, 1'b1, 32'h11111111};
    tbl[21] = '{1'b0, 2'b00, 11'h0, 11'h0, 3'd0, 3'd0, 2'b00, 11'h0, 11'h0, 32'h0, 32'h0, 2'b00, 1'b1, 11'h006, 2'b00, 1'b0, 11'h0, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[22] = '{1'b1, 2'b11, 11'h005, 11'h100, 3'd0, 3'd0, 2'b11, 11'h300, 11'h301, 32'h44444444, 32'h55555555, 2'b00, 1'b0, 11'h0, 2'b00, 1'b0, 11'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[23] = tbl[19];
    tbl[24] = tbl[19];
    tbl[25] = tbl[19];
    tbl[26] = '{1'b0, 2'b11, 11'h005, 11'h100, 3'd0, 3'd0, 2'b11, 11'h300, 11'h301, 32'h44444444, 32'h55555555, 2'b01, 1'b1, 11'h005, 2'b01, 1'b1, 11'h300, 2'b01, 2'b01, 1'b1, 32'h11111111};

    applyStimulus(tbl[0]);
    $display("[TB] reset and table vectors");
    runRange(0, 19);

    // Burst blocking: A len 7 alone, B raises next cycle and must wait 8 cycles
    $display("[TB] burst blocking sequence");
    ack_b_cycle  = -1;
    va_count     = 0;
    last_a_cycle = -1;
    vb_count     = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge sram_clock);
      bus.rd_req_a  = (c == 0);
      bus.rd_addr_a = 11'h200;
      bus.rd_len_a  = 3'd7;
      bus.rd_req_b  = (c > 0) && (ack_b_cycle < 0);
      bus.rd_addr_b = 11'h005;
      bus.rd_len_b  = 3'd0;
      #1;
      if (c == 0) check("blk rd_ack_a", 32'(bus.rd_ack_a), 32'd1);
      if (bus.rd_ack_b && (ack_b_cycle < 0)) ack_b_cycle = c;
      @(posedge sram_clock);
      #1;
      if (bus.rd_valid_a) begin
        va_count++;
        if (bus.rd_last_a) last_a_cycle = c;
      end
      if (bus.rd_valid_b) vb_count++;
    end
    check("blk rd_ack_b cycle", 32'(ack_b_cycle), 32'd8);
    check("blk rd_valid_a beats", 32'(va_count), 32'd8);
    check("blk rd_last_a cycle", 32'(last_a_cycle), 32'd7);
    check("blk rd_valid_b beats", 32'(vb_count), 32'd1);

    $display("[TB] reset mid-burst sequence");
    runRange(20, 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gip_sram_dp_arbiter.md
# gip_sram_dp_arbiter

Shares one simple dual-port 2048x32 SRAM macro between two read clients (A, B) and two write clients (A, B). Read port: round-robin arbitration with bursts of 1–8 words. Write port: independent single-beat round-robin arbitration. Sits between the GIP DDR emulation clients and the `memory_s_dp_2048x32`-style macro. The macro registers its read address and returns data in the following cycle.

## Interface
- BURST_BITS, 3, width of burst length fields; max burst = 2^BURST_BITS words
- sram_clock  in  1  single clock for block and SRAM
- sram_reset  in  1  reset; synchronous, active-high
- rd_req_a / rd_req_b  in  1  read request; held until acked
- rd_addr_a / rd_addr_b  in  11  burst start word address
- rd_len_a / rd_len_b  in  BURST_BITS  beats minus one
- rd_ack_a / rd_ack_b  out  1  request accepted this cycle (combinational)
- rd_valid_a / rd_valid_b  out  1  rd_data carries a beat for that client
- rd_last_a / rd_last_b  out  1  final beat of burst (qualified by valid)
- rd_data  out  32  shared read data (pass-through of sram_read_data)
- wr_req_a / wr_req_b  in  1  write request; held until acked
- wr_addr_a / wr_addr_b  in  11  write word address
- wr_data_a / wr_data_b  in  32  write data
- wr_ack_a / wr_ack_b  out  1  write performed this cycle (combinational)
- sram_read, sram_read_address[10:0]  out  SRAM read strobe / address
- sram_read_data  in  32  SRAM read data, valid cycle after strobe
- sram_write, sram_write_address[10:0], sram_write_data[31:0]  out  SRAM write port

## Operation
- Read FSM, two states:
  - IDLE: if any rd_req, the arbiter picks a winner X. Drive rd_ack_X=1 and sram_read=1 with address rd_addr_X in the same cycle. Capture owner, next address = rd_addr_X+1, remaining = rd_len_X.
    - remaining==0: stay IDLE. A new grant is possible next cycle, giving back-to-back single reads at 1/cycle.
    - Otherwise go to BURST.
  - BURST: sram_read=1 each cycle at the captured address. Address increments mod 2048 (0x7FF wraps to 0x000). remaining decrements. Return to IDLE after the beat where remaining was 1. No acks are issued in BURST; other requests wait.
- Read data path:
  - rd_valid_X and rd_last_X are registered. They are set the cycle after the corresponding issue.
  - rd_last goes with the final issued beat.
  - rd_data = sram_read_data combinationally. No backpressure.
- Round-robin arbitration (read and write use separate instances):
  - The pointer favours A after reset.
  - After a grant to X, the pointer favours the other client.
  - A lone requester is always granted.
- Writes:
  - Any cycle with a wr_req: the arbiter picks winner Y.
  - Drive sram_write=1 with Y's address and data, and wr_ack_Y=1, in the same cycle.
  - Writes are independent of the read FSM.
- Read/write collision (same address, same cycle): no hazard logic. The read beat returns the newly written data, matching macro behaviour.
- Reset:
  - State goes to IDLE, both pointers favour A.
  - rd_valid_* = 0 and rd_last_* = 0 on the cycle after reset is sampled.
  - While sram_reset=1, all acks, sram_read and sram_write are forced to 0.
  - A burst in progress is abandoned with no further valids. Clients must re-request.

## Timing
- Read latency: request seen in cycle N with grant → data valid in N+1. A burst of L+1 beats has valids in N+1..N+L+1, back to back.
- Write: ack and SRAM write happen in the same cycle the request wins.
- Combinational paths: rd_req/wr_req → ack and SRAM strobes; sram_read_data → rd_data.
- Registered: FSM state, owner, address, remaining count, valid/last flags, arbiter pointers.

## Structure
- Package `gip_sram_arb_pkg`:
  - SRAM_ADDR_W=11, SRAM_DATA_W=32
  - read FSM state enum {IDLE, BURST}
  - client id type (A=0, B=1)
- Sub-module `gip_rr_arb2`: 2-way round-robin arbiter.
  - Inputs: clock, reset, req[1:0], advance.
  - Outputs: one-hot grant.
  - Instantiated once for reads (advance only in IDLE) and once for writes.

## Test plan
- Single reads: preload 0x005=0x11111111. rd_req_a, addr 0x005, len 0 → ack same cycle; rd_valid_a, rd_last_a and rd_data=0x11111111 next cycle.
- Burst wrap: rd_req_b, addr 0x7FE, len 3 → SRAM addresses 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; 4 rd_valid_b; rd_last_b on the 4th.
- Fairness: rd_req_a and rd_req_b held high, both len 0 → grants alternate A, B, A, B at one per cycle; with writes held, wr_ack alternates the same way.
- Burst blocking: A len 7 granted, then B requests → rd_ack_b exactly 8 cycles after rd_ack_a.
- Collision: write 0xDEADBEEF to 0x100 in the same cycle as a read of 0x100 → next-cycle rd_data = 0xDEADBEEF.
- Reset mid-burst: sram_reset in the 3rd beat of a len-7 burst → no valids after the reset cycle; FSM in IDLE; next simultaneous requests grant A first.
